fp_mult_pipe: RTL and testbench
===============================

Name: fp_mult_pipe

Overview:
- Pipelined, parametrised IEEE-754-style floating-point multiplier.
- Successor to the single-cycle combinational multiplier.
- Adds:
  - configurable exponent/mantissa widths;
  - a 3-stage pipeline with valid/ready handshake and back-pressure;
  - round-to-nearest-even;
  - special-value handling (zero, inf, NaN);
  - overflow/underflow detection with exception flags.
- Sits in the accelerator datapath between operand issue and the result writeback FIFO.

Parameters:
- EXP_W, 8, exponent field width (>=4).
- MAN_W, 23, stored mantissa field width, excluding the hidden bit (>=4).
- DATA_WIDTH, 1+EXP_W+MAN_W, operand/result width. Derived; must not be overridden independently.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- data_1  in  DATA_WIDTH  operand A.
- data_2  in  DATA_WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- data_prod  out  DATA_WIDTH  packed product.
- flags  out  4  {invalid, overflow, underflow, inexact}, aligned with data_prod.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - All stage valid bits, out_valid, data_prod and flags clear to 0.
  - In-flight operations are discarded.
  - in_ready=1 in the first cycle after reset deasserts.
- Handshake and stalling:
  - Transfer in on in_valid&&in_ready; transfer out on out_valid&&out_ready.
  - Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - When adv=0, all stages hold; data_prod/flags stay stable while out_valid=1.
  - Bubbles are not compressed during a stall (simple global stall).
- Latency and throughput:
  - Exactly 3 cycles, acceptance edge to out_valid, when unstalled.
  - Throughput 1 op/cycle.
  - Results leave strictly in issue order.
- Stage 1 (unpack):
  - Register sign = sA^sB.
  - Register classes per operand: zero (exp==0, any mantissa; subnormal inputs flush to zero, no flag), inf (exp all-ones, man==0), NaN (exp all-ones, man!=0).
  - Register significands {1,man}, each MAN_W+1 bits.
  - Register biased exponent sum eA+eB-BIAS, BIAS = 2^(EXP_W-1)-1, signed width EXP_W+2.
- Stage 2: register full product, 2*(MAN_W+1) bits, unsigned.
- Stage 3 (normalize/round/pack):
  - Product in [1,4): if the top bit is set, shift right 1 and exp+1.
  - Guard = first dropped bit; sticky = OR of the rest.
  - Round-to-nearest-even: increment if guard && (sticky || lsb).
  - A mantissa carry-out sets mantissa to 0 and exp+1.
  - inexact = guard||sticky.
- Exceptions and special values:
  - Priority order: NaN > invalid > inf > zero > overflow/underflow.
  - Any NaN input, or inf*zero: canonical NaN (sign 0, exp all-ones, man MSB=1, rest 0). invalid=1 only for inf*zero or a signalling NaN (man MSB=0).
  - Inf with a non-zero operand: signed inf, no flags.
  - Zero with a finite operand: signed zero, no flags.
  - Final exp >= 2^EXP_W-1: signed inf, overflow=1, inexact=1.
  - Final exp <= 0: signed zero (no subnormal output), underflow=1, inexact=1.
- Flags are per-result, not sticky.
- No X propagation: data_prod holds its last value when out_valid=0.

Test Plan:
- 0x3FC00000 * 0x40000000, out_ready=1 → data_prod=0x40400000, flags=0, out_valid exactly 3 cycles after acceptance.
- 0x3F800001 * 0x3F800001 → 0x3F800002, flags=0001 (inexact, round-down path). 0x3F800003 * 0x3F800003 → 0x3F800006, inexact (tie-to-even check via sticky).
- 0x7F800000 * 0x00000000 → 0x7FC00000, invalid=1. 0xFF800000 * 0x40000000 → 0xFF800000, flags=0.
- 0x7F000000 * 0x7F000000 → 0x7F800000, overflow+inexact. 0x00800000 * 0x00800000 → 0x00000000, underflow+inexact. 0x00000001 * 0x3F800000 → 0x00000000, flags=0.
- Issue 5 ops back-to-back, hold out_ready=0 for 6 cycles → in_ready drops while out_valid=1; data_prod held stable; all 5 results emerge in order after release, no loss or duplication.
- Assert rst for 1 cycle with 3 ops in flight → out_valid=0 next cycle, in_ready=1, none of the pending results ever appear; next op completes normally in 3 cycles.
- Regression (EXP_W=5, MAN_W=10, half precision): 0x3E00 * 0x4000 → 0x4200; 0x7BFF * 0x4000 → 0x7C00 with overflow.

Source files
------------

// File: rtl/fp_mult_pipe_if.sv
// Operand/result handshake bundle for fp_mult_pipe.
// master drives operands and result acceptance; slave is the multiplier.
interface fp_mult_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned DATA_WIDTH = 1 + EXP_W + MAN_W;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] data_1;
  logic [DATA_WIDTH-1:0] data_2;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] data_prod;
  logic [3:0]            flags;

  modport master (
    output in_valid, data_1, data_2, out_ready,
    input  in_ready, out_valid, data_prod, flags
  );

  modport slave (
    input  in_valid, data_1, data_2, out_ready,
    output in_ready, out_valid, data_prod, flags
  );
endinterface

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier: unpack, multiply, normalize/round/pack.
// Round-to-nearest-even, subnormals flushed to zero on input and output, global stall.
// flags = {invalid, overflow, underflow, inexact}, aligned with data_prod.
module fp_mult_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic          clk,
  input  logic          rst,
  fp_mult_pipe_if.slave bus
);
  localparam int unsigned DATA_WIDTH = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W      = MAN_W + 1;
  localparam int unsigned PROD_W     = 2 * SIG_W;
  localparam int unsigned XW         = EXP_W + 2;
  localparam int          BIAS_I     = (1 << (EXP_W - 1)) - 1;
  localparam int          EXP_MAX_I  = (1 << EXP_W) - 1;
  localparam logic signed [XW-1:0] BIAS     = XW'(BIAS_I);
  localparam logic signed [XW-1:0] EXP_MAX  = XW'(EXP_MAX_I);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;

  // Global advance: every stage moves together unless the output is blocked.
  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // ---------------- Stage 1 inputs (combinational unpack) ----------------
  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     ma, mb;
  logic [1:0]           cls_zero, cls_inf, cls_nan, cls_snan;
  logic signed [XW-1:0] exp_sum;

  // Classify operands; index 1 is operand A, index 0 is operand B.
  always_comb begin
    ea          = bus.data_1[DATA_WIDTH-2 -: EXP_W];
    eb          = bus.data_2[DATA_WIDTH-2 -: EXP_W];
    ma          = bus.data_1[MAN_W-1:0];
    mb          = bus.data_2[MAN_W-1:0];
    cls_zero    = {ea == '0, eb == '0};
    cls_inf     = {(&ea) && (ma == '0), (&eb) && (mb == '0)};
    cls_nan     = {(&ea) && (ma != '0), (&eb) && (mb != '0)};
    cls_snan    = {cls_nan[1] && !ma[MAN_W-1], cls_nan[0] && !mb[MAN_W-1]};
    exp_sum     = XW'(ea) + XW'(eb) - BIAS;
  end

  // ---------------- Stage 1 registers ----------------
  logic                 s1_valid_q;
  logic                 s1_sign_q;
  logic [1:0]           s1_zero_q, s1_inf_q, s1_nan_q, s1_snan_q;
  logic [SIG_W-1:0]     s1_sig_a_q, s1_sig_b_q;
  logic signed [XW-1:0] s1_exp_q;

  // Stage 1 valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= bus.in_valid;
    end
  end

  // Stage 1 payload: sign, operand classes, significands with hidden bit, biased exponent.
  always_ff @(posedge clk) begin
    if (adv && bus.in_valid) begin
      s1_sign_q  <= bus.data_1[DATA_WIDTH-1] ^ bus.data_2[DATA_WIDTH-1];
      s1_zero_q  <= cls_zero;
      s1_inf_q   <= cls_inf;
      s1_nan_q   <= cls_nan;
      s1_snan_q  <= cls_snan;
      s1_sig_a_q <= {1'b1, ma};
      s1_sig_b_q <= {1'b1, mb};
      s1_exp_q   <= exp_sum;
    end
  end

  // ---------------- Stage 2 registers ----------------
  logic                 s2_valid_q;
  logic                 s2_sign_q;
  logic [1:0]           s2_zero_q, s2_inf_q, s2_nan_q, s2_snan_q;
  logic [PROD_W-1:0]    s2_prod_q;
  logic signed [XW-1:0] s2_exp_q;

  // Stage 2 valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
    end
  end

  // Stage 2 payload: full unsigned significand product, classes forwarded.
  always_ff @(posedge clk) begin
    if (adv && s1_valid_q) begin
      s2_sign_q <= s1_sign_q;
      s2_zero_q <= s1_zero_q;
      s2_inf_q  <= s1_inf_q;
      s2_nan_q  <= s1_nan_q;
      s2_snan_q <= s1_snan_q;
      s2_prod_q <= PROD_W'(s1_sig_a_q) * PROD_W'(s1_sig_b_q);
      s2_exp_q  <= s1_exp_q;
    end
  end

  // ---------------- Stage 3 (combinational normalize/round/pack) ----------------
  logic                  top;
  logic [PROD_W-1:0]     norm;
  logic [MAN_W-1:0]      man, man_r;
  logic                  guard, sticky, round_up, carry;
  logic signed [XW-1:0]  exp_f;
  logic                  inf_zero, nan_res;
  logic [DATA_WIDTH-1:0] res;
  logic [3:0]            res_flags;

  // Normalize to [1,2), round to nearest even, then resolve specials and range.
  always_comb begin
    top    = s2_prod_q[PROD_W-1];
    norm   = top ? s2_prod_q : (s2_prod_q << 1);
    // norm layout: [2M+1] hidden, [2M:M+1] mantissa, [M] guard, [M-1:0] sticky bits.
    man    = norm[PROD_W-2 -: MAN_W];
    guard  = norm[MAN_W];
    sticky = |norm[MAN_W-1:0];
    round_up       = guard && (sticky || man[0]);
    {carry, man_r} = {1'b0, man} + {{MAN_W{1'b0}}, round_up};
    exp_f  = s2_exp_q + XW'(top) + XW'(carry);

    inf_zero = (s2_inf_q[1] && s2_zero_q[0]) || (s2_zero_q[1] && s2_inf_q[0]);
    nan_res  = (|s2_nan_q) || inf_zero;

    res       = '0;
    res_flags = '0;
    if (nan_res) begin
      res          = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      res_flags[3] = inf_zero || (|s2_snan_q);
    end else if (|s2_inf_q) begin
      res = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (|s2_zero_q) begin
      res = {s2_sign_q, {(EXP_W+MAN_W){1'b0}}};
    end else if (exp_f >= EXP_MAX) begin
      res       = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_flags = 4'b0101;
    end else if (exp_f <= EXP_ZERO) begin
      res       = {s2_sign_q, {(EXP_W+MAN_W){1'b0}}};
      res_flags = 4'b0011;
    end else begin
      res       = {s2_sign_q, exp_f[EXP_W-1:0], man_r};
      res_flags = {3'b000, guard || sticky};
    end
  end

  // ---------------- Stage 3 / output registers ----------------
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] data_prod_q;
  logic [3:0]            flags_q;

  // Output register; result fields only change when a new result lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      data_prod_q <= '0;
      flags_q     <= '0;
    end else if (adv) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        data_prod_q <= res;
        flags_q     <= res_flags;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.data_prod = data_prod_q;
  assign bus.flags     = flags_q;
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe: single and half precision instances, a numeric reference
// model with a scoreboard on the single-precision output, and directed vectors.
module tb_fp_mult_pipe;
  typedef longint unsigned u64_t;
  typedef struct {
    logic [31:0] d;
    logic [3:0]  f;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_mult_pipe_if #(.EXP_W(8), .MAN_W(23)) sp_if ();
  fp_mult_pipe_if #(.EXP_W(5), .MAN_W(10)) hp_if ();

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) u_sp (.clk(clk), .rst(rst), .bus(sp_if.slave));
  fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) u_hp (.clk(clk), .rst(rst), .bus(hp_if.slave));

  int   checks = 0;
  int   passed = 0;
  int   transfers = 0;
  exp_t sb_q[$];

  logic [31:0] va[10], vb[10], vp[10];
  logic [3:0]  vf[10];

  task automatic check(input string name, input u64_t act, input u64_t req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Reference: exact integer product, round by comparing the dropped remainder with half an ulp.
  function automatic void fp_model(input u64_t a, input u64_t b, input int ew, input int mw,
                                   output u64_t res, output logic [3:0] fl);
    u64_t ones, mmask, ea, eb, ma, mb, sgn, p, keep, rem, half;
    bit   za, zb, ia, ib, na, nb, sna, snb, infzero, inexact;
    int   bias, msb, sh, e;
    ones  = (64'd1 << ew) - 1;
    mmask = (64'd1 << mw) - 1;
    ea = (a >> mw) & ones;  eb = (b >> mw) & ones;
    ma = a & mmask;         mb = b & mmask;
    sgn = ((a ^ b) >> (ew + mw)) & 64'd1;
    za = (ea == 0);  zb = (eb == 0);
    ia = (ea == ones) && (ma == 0);  ib = (eb == ones) && (mb == 0);
    na = (ea == ones) && (ma != 0);  nb = (eb == ones) && (mb != 0);
    sna = na && (((ma >> (mw - 1)) & 64'd1) == 0);
    snb = nb && (((mb >> (mw - 1)) & 64'd1) == 0);
    infzero = (ia && zb) || (za && ib);
    bias = (1 << (ew - 1)) - 1;
    fl = 4'b0000;
    if (na || nb || infzero) begin
      res   = (ones << mw) | (64'd1 << (mw - 1));
      fl[3] = infzero || sna || snb;
    end else if (ia || ib) begin
      res = (sgn << (ew + mw)) | (ones << mw);
    end else if (za || zb) begin
      res = sgn << (ew + mw);
    end else begin
      p = ((64'd1 << mw) | ma) * ((64'd1 << mw) | mb);
      msb = 0;
      for (int i = 0; i < 64; i++) if (p[i]) msb = i;
      sh   = msb - mw;
      keep = p >> sh;
      rem  = p & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      inexact = (rem != 0);
      if (rem > half || (rem == half && keep[0])) keep++;
      e = int'(ea) + int'(eb) - bias + (msb - 2 * mw);
      if (keep == (64'd1 << (mw + 1))) begin
        keep >>= 1;
        e++;
      end
      if (e >= int'(ones)) begin
        res = (sgn << (ew + mw)) | (ones << mw);
        fl  = 4'b0101;
      end else if (e <= 0) begin
        res = sgn << (ew + mw);
        fl  = 4'b0011;
      end else begin
        res = (sgn << (ew + mw)) | (u64_t'(e) << mw) | (keep & mmask);
        fl  = {3'b000, inexact};
      end
    end
  endfunction

  // Scoreboard on the single-precision instance: check every valid output cycle, pop on transfer.
  always @(negedge clk) begin
    u64_t       r;
    logic [3:0] f;
    exp_t       e;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (sp_if.out_valid) begin
        if (sb_q.size() == 0) begin
          check("spurious_out_valid", sp_if.out_valid, 0);
        end else begin
          check("sb_data", sp_if.data_prod, sb_q[0].d);
          check("sb_flags", sp_if.flags, sb_q[0].f);
          if (sp_if.out_ready) begin
            void'(sb_q.pop_front());
            transfers++;
          end
        end
      end
      if (sp_if.in_valid && sp_if.in_ready) begin
        fp_model(sp_if.data_1, sp_if.data_2, 8, 23, r, f);
        e.d = r[31:0];
        e.f = f;
        sb_q.push_back(e);
      end
    end
  end

  task automatic sp_issue(input logic [31:0] a, input logic [31:0] b);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    sp_if.in_valid = 1'b1;
    sp_if.data_1   = a;
    sp_if.data_2   = b;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = sp_if.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check("issue_timeout", 0, 1);
    sp_if.in_valid = 1'b0;
  endtask

  // One op on an idle pipe: latency, literal result, and the model pinned to the same literal.
  task automatic run_one(input int i, input string name);
    int         cnt;
    u64_t       r;
    logic [3:0] f;
    fp_model(va[i], vb[i], 8, 23, r, f);
    check({"model_", name}, r, vp[i]);
    check({"model_flags_", name}, f, vf[i]);
    sp_if.out_ready = 1'b1;
    sp_issue(va[i], vb[i]);
    cnt = 0;
    while (!sp_if.out_valid && cnt < 10) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    // out_valid rises on the third rising edge counting the acceptance edge.
    check({"latency_", name}, cnt, 2);
    check({"data_", name}, sp_if.data_prod, vp[i]);
    check({"flags_", name}, sp_if.flags, vf[i]);
    @(posedge clk);
    #1;
  endtask

  task automatic hp_run(input logic [15:0] a, input logic [15:0] b, input logic [15:0] p,
                        input logic [3:0] fl, input string name);
    int         cnt;
    u64_t       r;
    logic [3:0] f;
    fp_model(a, b, 5, 10, r, f);
    check({"hp_model_", name}, r, p);
    check({"hp_model_flags_", name}, f, fl);
    hp_if.out_ready = 1'b1;
    hp_if.in_valid  = 1'b1;
    hp_if.data_1    = a;
    hp_if.data_2    = b;
    @(negedge clk);
    check({"hp_in_ready_", name}, hp_if.in_ready, 1);
    @(posedge clk);
    #1;
    hp_if.in_valid = 1'b0;
    cnt = 0;
    while (!hp_if.out_valid && cnt < 10) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check({"hp_latency_", name}, cnt, 2);
    check({"hp_data_", name}, hp_if.data_prod, p);
    check({"hp_flags_", name}, hp_if.flags, fl);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int         t0, n;
    logic [31:0] held;

    va[0] = 32'h3FC00000; vb[0] = 32'h40000000; vp[0] = 32'h40400000; vf[0] = 4'b0000;
    va[1] = 32'h3F800001; vb[1] = 32'h3F800001; vp[1] = 32'h3F800002; vf[1] = 4'b0001;
    va[2] = 32'h3F800003; vb[2] = 32'h3F800003; vp[2] = 32'h3F800006; vf[2] = 4'b0001;
    va[3] = 32'h7F800000; vb[3] = 32'h00000000; vp[3] = 32'h7FC00000; vf[3] = 4'b1000;
    va[4] = 32'hFF800000; vb[4] = 32'h40000000; vp[4] = 32'hFF800000; vf[4] = 4'b0000;
    va[5] = 32'h7F000000; vb[5] = 32'h7F000000; vp[5] = 32'h7F800000; vf[5] = 4'b0101;
    va[6] = 32'h00800000; vb[6] = 32'h00800000; vp[6] = 32'h00000000; vf[6] = 4'b0011;
    va[7] = 32'h00000001; vb[7] = 32'h3F800000; vp[7] = 32'h00000000; vf[7] = 4'b0000;
    va[8] = 32'h7FA00000; vb[8] = 32'h3F800000; vp[8] = 32'h7FC00000; vf[8] = 4'b1000;
    va[9] = 32'hC0000000; vb[9] = 32'h3FC00000; vp[9] = 32'hC0400000; vf[9] = 4'b0000;

    rst = 1'b1;
    sp_if.in_valid = 1'b0; sp_if.out_ready = 1'b1; sp_if.data_1 = '0; sp_if.data_2 = '0;
    hp_if.in_valid = 1'b0; hp_if.out_ready = 1'b1; hp_if.data_1 = '0; hp_if.data_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", sp_if.out_valid, 0);
    check("rst_data_prod", sp_if.data_prod, 0);
    check("rst_flags", sp_if.flags, 0);
    check("rst_in_ready", sp_if.in_ready, 1);
    check("rst_hp_out_valid", hp_if.out_valid, 0);

    run_one(0, "mul_1p5x2");
    run_one(1, "round_down");
    run_one(2, "sticky_no_tie");
    run_one(3, "inf_x_zero");
    run_one(4, "neg_inf");
    run_one(5, "overflow");
    run_one(6, "underflow");
    run_one(7, "subnormal_flush");
    run_one(8, "snan");
    run_one(9, "neg_finite");

    // Back-pressure: three fill the pipe, the fourth waits while the output is blocked.
    t0 = transfers;
    sp_if.out_ready = 1'b0;
    sp_issue(va[0], vb[0]);
    sp_issue(va[1], vb[1]);
    sp_issue(va[2], vb[2]);
    sp_if.in_valid = 1'b1;
    sp_if.data_1   = va[3];
    sp_if.data_2   = vb[3];
    check("stall_out_valid", sp_if.out_valid, 1);
    check("stall_in_ready", sp_if.in_ready, 0);
    held = sp_if.data_prod;
    check("stall_first_result", held, vp[0]);
    repeat (6) begin
      @(posedge clk);
      #1;
      check("stall_hold_data", sp_if.data_prod, held);
      check("stall_hold_in_ready", sp_if.in_ready, 0);
    end
    sp_if.out_ready = 1'b1;
    sp_issue(va[3], vb[3]);
    sp_issue(va[4], vb[4]);
    n = 0;
    while ((sb_q.size() != 0 || sp_if.out_valid) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("stall_drain_empty", sb_q.size(), 0);
    check("stall_transfers", transfers - t0, 5);

    // Reset with three ops in flight; none may ever surface.
    sp_if.out_ready = 1'b0;
    sp_issue(va[5], vb[5]);
    sp_issue(va[6], vb[6]);
    sp_issue(va[9], vb[9]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    t0 = transfers;
    check("rst_flight_out_valid", sp_if.out_valid, 0);
    check("rst_flight_in_ready", sp_if.in_ready, 1);
    sp_if.out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("rst_flight_no_output", sp_if.out_valid, 0);
    end
    check("rst_flight_transfers", transfers - t0, 0);
    run_one(0, "after_reset");

    hp_run(16'h3E00, 16'h4000, 16'h4200, 4'b0000, "mul_1p5x2");
    hp_run(16'h7BFF, 16'h4000, 16'h7C00, 4'b0101, "overflow");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
